// File: rtl/dct_mac_sched_if.sv
// Handshake and datapath-control bundle between the MAC sequencer,
// the sample source, the macu datapath and the result consumer.
interface dct_mac_sched_if #(
    parameter int N_TAPS = 8,
    parameter int ROWS   = 8
);
    logic                      s_valid;
    logic                      s_ready;
    logic [$clog2(N_TAPS)-1:0] coef_sel;
    logic                      mac_clr;
    logic                      mac_ena;
    logic                      res_valid;
    logic                      res_ready;
    logic [$clog2(ROWS)-1:0]   row_idx;
    logic                      block_done;
    logic                      busy;

    modport master (
        output s_valid, res_ready,
        input  s_ready, coef_sel, mac_clr, mac_ena,
        input  res_valid, row_idx, block_done, busy
    );

    modport slave (
        input  s_valid, res_ready,
        output s_ready, coef_sel, mac_clr, mac_ena,
        output res_valid, row_idx, block_done, busy
    );
endinterface

// File: rtl/dct_mac_sched.sv
// MAC sequencer for one fdct_zigzag DCT unit: taps in, pipeline drain,
// result handshake out, row/block tracking.
module dct_mac_sched #(
    parameter int N_TAPS   = 8,
    parameter int ROWS     = 8,
    parameter int MULT_LAT = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_abort,
    dct_mac_sched_if.slave    bus
);
    localparam int TW = $clog2(N_TAPS);
    localparam int RW = $clog2(ROWS);
    localparam int DW = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DRAIN,
        ST_HOLD
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [TW-1:0] r_tap, w_tap_nxt;
    logic [DW-1:0] r_dcnt, w_dcnt_nxt;
    logic [RW-1:0] r_row, w_row_nxt;

    logic w_ready;
    logic w_accept;
    logic w_last;
    logic w_hs;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_tap   <= '0;
            r_dcnt  <= '0;
            r_row   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tap   <= w_tap_nxt;
            r_dcnt  <= w_dcnt_nxt;
            r_row   <= w_row_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tap_nxt   = r_tap;
        w_dcnt_nxt  = r_dcnt;
        w_row_nxt   = r_row;

        w_ready  = ((r_state == ST_IDLE) || (r_state == ST_ACCUM)) && !i_rst;
        w_accept = w_ready && bus.s_valid;
        w_last   = (r_tap == TW'(N_TAPS - 1));
        w_hs     = (r_state == ST_HOLD) && bus.res_ready && !i_rst;

        unique case (r_state)
            ST_IDLE, ST_ACCUM: begin
                if (w_accept) begin
                    if (w_last) begin
                        w_tap_nxt   = '0;
                        w_dcnt_nxt  = DW'(MULT_LAT - 1);
                        w_state_nxt = ST_DRAIN;
                    end else begin
                        w_tap_nxt   = r_tap + 1'b1;
                        w_state_nxt = ST_ACCUM;
                    end
                end
            end
            ST_DRAIN: begin
                if (r_dcnt == '0) begin
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_dcnt_nxt = r_dcnt - 1'b1;
                end
            end
            ST_HOLD: begin
                if (w_hs) begin
                    w_state_nxt = ST_IDLE;
                    w_row_nxt   = r_row + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Flush wins over any same-cycle accept or result handshake
        if (i_abort) begin
            w_state_nxt = ST_IDLE;
            w_tap_nxt   = '0;
            w_dcnt_nxt  = '0;
            w_row_nxt   = r_row;
        end
    end

    assign bus.s_ready    = w_ready;
    assign bus.coef_sel   = r_tap;
    assign bus.mac_ena    = w_accept && !i_abort;
    assign bus.mac_clr    = w_accept && !i_abort && (r_tap == '0);
    assign bus.res_valid  = (r_state == ST_HOLD);
    assign bus.row_idx    = r_row;
    assign bus.block_done = w_hs && !i_abort
                            && (r_row == RW'(ROWS - 1));
    assign bus.busy       = (r_state != ST_IDLE) || (r_tap != '0);

endmodule

// File: tb/tb_dct_mac_sched.sv
// Directed bench for dct_mac_sched: tap sequencing, drain latency,
// backpressure, bubbles, block wrap, abort and reset-in-hold.
module tb_dct_mac_sched;
    localparam int N_TAPS   = 8;
    localparam int ROWS     = 8;
    localparam int MULT_LAT = 2;

    logic clk;
    logic rst;
    logic abort;

    dct_mac_sched_if #(.N_TAPS(N_TAPS), .ROWS(ROWS)) bus ();

    dct_mac_sched #(
        .N_TAPS   (N_TAPS),
        .ROWS     (ROWS),
        .MULT_LAT (MULT_LAT)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_abort (abort),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    int m_row = 0;
    int mac_cnt = 0;
    int clr_cnt = 0;
    int blk_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Drive inputs just after the edge, then settle to mid-cycle
    task automatic drive(input logic sv, input logic rr, input logic ab);
        bus.s_valid   = sv;
        bus.res_ready = rr;
        abort         = ab;
        #4;
        if (bus.mac_ena)    mac_cnt++;
        if (bus.mac_clr)    clr_cnt++;
        if (bus.block_done) blk_cnt++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed_row(input bit gap);
        for (int k = 0; k < N_TAPS; k++) begin
            if (gap && k > 0) begin
                drive(1'b0, 1'b0, 1'b0);
                chk("gap_ena", bus.mac_ena, 0);
                chk("gap_sel", bus.coef_sel, k);
                step();
            end
            drive(1'b1, 1'b0, 1'b0);
            chk("tap_rdy", bus.s_ready, 1);
            chk("tap_ena", bus.mac_ena, 1);
            chk("tap_sel", bus.coef_sel, k);
            chk("tap_clr", bus.mac_clr, (k == 0));
            if (k == 0) chk("tap_row", bus.row_idx, m_row);
            step();
        end
        exp_q.push_back(m_row);
    endtask

    // Waits out the drain with s_valid held high, holds the result
    // for 'hold' cycles of res_ready=0, then completes the handshake.
    task automatic result(input int hold);
        int  c;
        int  seen;
        int  want;
        bit  done;
        logic rr;
        c = 0;
        seen = 0;
        done = 0;
        while (!done && c < 40) begin
            c++;
            rr = (seen >= hold);
            drive(1'b1, rr, 1'b0);
            chk("drn_ena", bus.mac_ena, 0);
            chk("drn_rdy", bus.s_ready, 0);
            if (bus.res_valid) begin
                if (seen == 0) chk("latency", c, MULT_LAT + 1);
                chk("hold_busy", bus.busy, 1);
                if (rr) begin
                    if (exp_q.size() == 0) begin
                        chk("sb_empty", 1, 0);
                    end else begin
                        want = exp_q.pop_front();
                        chk("sb_row", bus.row_idx, want);
                        chk("sb_done", bus.block_done,
                            (want == ROWS - 1));
                    end
                    m_row = (m_row + 1) % ROWS;
                    done = 1;
                end else begin
                    seen++;
                end
            end else begin
                chk("drn_done", bus.block_done, 0);
            end
            step();
        end
        if (!done) chk("res_timeout", 0, 1);
        drive(1'b0, 1'b0, 1'b0);
        chk("post_vld", bus.res_valid, 0);
        chk("post_rdy", bus.s_ready, 1);
        chk("post_busy", bus.busy, 0);
        chk("post_row", bus.row_idx, m_row);
        step();
    endtask

    initial begin
        int m0;
        int c0;
        int b0;
        bit got;

        rst = 1'b1;
        abort = 1'b0;
        bus.s_valid = 1'b0;
        bus.res_ready = 1'b0;
        step();
        step();
        rst = 1'b0;

        drive(1'b0, 1'b0, 1'b0);
        chk("rst_vld", bus.res_valid, 0);
        chk("rst_done", bus.block_done, 0);
        chk("rst_ena", bus.mac_ena, 0);
        chk("rst_clr", bus.mac_clr, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_sel", bus.coef_sel, 0);
        chk("rst_row", bus.row_idx, 0);
        chk("rst_rdy", bus.s_ready, 1);
        step();

        // Plain row, immediate acceptance
        feed_row(1'b0);
        result(0);

        // Result backpressure
        feed_row(1'b0);
        result(10);

        // Bubbles between samples
        m0 = mac_cnt;
        c0 = clr_cnt;
        feed_row(1'b1);
        chk("bub_ena_cnt", mac_cnt - m0, N_TAPS);
        chk("bub_clr_cnt", clr_cnt - c0, 1);
        result(2);

        // Rows up to and across the block boundary
        b0 = blk_cnt;
        while (m_row != 0) begin
            feed_row(1'b0);
            result(0);
        end
        chk("blk_cnt", blk_cnt - b0, 1);
        chk("blk_wrap", bus.row_idx, 0);

        // Abort mid-row
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 1'b0);
            chk("ab_pre_sel", bus.coef_sel, k);
            step();
        end
        drive(1'b1, 1'b0, 1'b1);
        chk("ab_ena", bus.mac_ena, 0);
        chk("ab_clr", bus.mac_clr, 0);
        step();
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 1'b0, 1'b0);
            chk("ab_sel", bus.coef_sel, 0);
            chk("ab_vld", bus.res_valid, 0);
            chk("ab_busy", bus.busy, 0);
            chk("ab_row", bus.row_idx, m_row);
            step();
        end
        feed_row(1'b0);
        result(0);

        // Reset while a result is pending
        feed_row(1'b0);
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            drive(1'b1, 1'b0, 1'b0);
            chk("rh_ena", bus.mac_ena, 0);
            got = bus.res_valid;
            step();
        end
        chk("rh_seen", got, 1);
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        chk("rh_pend", bus.res_valid, 1);
        step();
        rst = 1'b0;
        void'(exp_q.pop_front());
        m_row = 0;
        drive(1'b0, 1'b1, 1'b0);
        chk("rh_vld", bus.res_valid, 0);
        chk("rh_done", bus.block_done, 0);
        chk("rh_ena2", bus.mac_ena, 0);
        chk("rh_busy", bus.busy, 0);
        chk("rh_sel", bus.coef_sel, 0);
        chk("rh_row", bus.row_idx, 0);
        chk("rh_rdy", bus.s_ready, 1);
        step();
        feed_row(1'b0);
        result(0);

        chk("sb_left", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
